// File: rtl/jellyvl_stream_pkg.sv
// Shared helpers for the jellyvl stream blocks: lane slicing and keep-mask generation.
package jellyvl_stream_pkg;

  localparam int unsigned MAX_LANES = 64;

  // Lane k of a packed word starts at bit k*unit_bits.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned unit_bits);
    return lane * unit_bits;
  endfunction

  // Low-ones mask covering lanes 0..cnt, clipped to n lanes.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned cnt, input int unsigned n);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i <= cnt && i < n) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/jellyvl_stream_packer.sv
// Narrow-to-wide stream packer: N beats of UNIT_BITS become one registered wide word,
// with s_last closing a partial word early and m_keep marking the filled lanes.
module jellyvl_stream_packer
  import jellyvl_stream_pkg::*;
#(
  parameter int unsigned UNIT_BITS = 8,
  parameter int unsigned N         = 4,
  parameter int unsigned CNT_BITS  = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,

  input  logic [UNIT_BITS-1:0]   s_data,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,

  output logic [N*UNIT_BITS-1:0] m_data,
  output logic [N-1:0]           m_keep,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int unsigned WORD_BITS = N * UNIT_BITS;

  logic [CNT_BITS-1:0]  cnt_q,     cnt_d;
  logic [WORD_BITS-1:0] acc_q,     acc_d;
  logic [WORD_BITS-1:0] m_data_q,  m_data_d;
  logic [N-1:0]         m_keep_q,  m_keep_d;
  logic                 m_last_q,  m_last_d;
  logic                 m_valid_q, m_valid_d;

  logic [WORD_BITS-1:0] word_c;
  logic                 accept_c;
  logic                 complete_c;

  // Input side only ever waits on the output register, never on the beat itself.
  assign s_ready = !m_valid_q || m_ready;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    word_c    = acc_q;

    accept_c   = s_valid && s_ready && cke;
    complete_c = accept_c && (s_last || (cnt_q == CNT_BITS'(N - 1)));

    // Accumulator lanes above cnt are always zero, so word_c is already the flushed word.
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CNT_BITS'(k)) begin
        word_c[lane_lo(k, UNIT_BITS) +: UNIT_BITS] = s_data;
      end
    end

    if (cke && m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (complete_c) begin
      m_data_d  = word_c;
      m_keep_d  = N'(keep_mask(32'(cnt_q), N));
      m_last_d  = s_last;
      m_valid_d = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
    end else if (accept_c) begin
      acc_d = word_c;
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule
